z80_prog_rom: RTL and testbench
===============================

Z80_PROG_ROM -- requirements
Module: z80_prog_rom

Interface
REQ-001 Parameter AW, default 8: address width in bits.
REQ-002 Parameter DW, default 8: data width in bits.
REQ-003 Parameter DEPTH, default 256: number of implemented words, at most 2**AW.
REQ-004 Parameter WAIT_CYC, default 1, range 0..7: wait states inserted per access.
REQ-005 Port clk, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port n_ce, input, 1: chip enable, active-low; the access runs while low.
REQ-008 Port n_oe, input, 1: output enable, active-low.
REQ-009 Port addr, input, AW: read address.
REQ-010 Port dout, output, DW: registered read data.
REQ-011 Port dout_en, output, 1: high when dout is to be driven onto the CPU bus.
REQ-012 Port n_wait, output, 1: active-low wait request to the CPU.
REQ-013 Ports ld_we (input, 1), ld_addr (input, AW) and ld_data (input, DW): loader write port, present only under the REQ-029 macro.

Function
REQ-014 FSM states: IDLE, WAIT, DATA; registered state.
REQ-015 IDLE: on n_ce sampled low, latch addr into the access register; go to WAIT if WAIT_CYC>0, else DATA.
REQ-016 WAIT: n_wait=0; stay exactly WAIT_CYC cycles (counter), then go to DATA.
REQ-017 On the edge entering DATA: dout <= mem[latched addr]; n_wait=1.
REQ-018 DATA: dout held; dout_en = ~n_oe sampled each cycle (registered, 1-cycle delay).
REQ-019 n_ce sampled high in WAIT or DATA: next state IDLE, dout_en 0, dout all-ones, n_wait 1 (abort allowed).
REQ-020 addr changes while n_ce is low are ignored; a new access requires n_ce high for at least one cycle.
REQ-021 Latched address >= DEPTH: dout all-ones, no wrap-around.
REQ-022 Total latency: n_ce low sampled at cycle 0 -> dout valid at cycle 1+WAIT_CYC.
REQ-023 dout_en is never 1 outside DATA.
REQ-024 Loader write (ld_we=1, ld_addr<DEPTH) updates mem at the edge; ld_addr>=DEPTH is ignored.
REQ-025 Write and read capture of the same address on the same edge: dout gets the old data (read-before-write).
REQ-026 Loader writes are accepted in any FSM state, including during reset.

Reset
REQ-027 rst=1 at an edge: state IDLE, counter 0, dout all-ones, dout_en 0, n_wait 1; takes priority over all transitions, including mid-access.
REQ-028 Memory contents are not cleared by rst; words not written by the loader hold the default image: 3E 00 3C C2 02 00 C3 06 00 at addresses 0..8, FF elsewhere.

Configuration
REQ-029 Macro Z80_PROG_ROM_LOAD_EN defined: ld_* ports and the write path exist; the power-up contents are the default image.
REQ-030 Macro Z80_PROG_ROM_LOAD_EN undefined: no ld_* ports; contents are constant (default image), synthesizable as ROM.

Structure
REQ-031 Shared package z80_mc_pkg holds the FSM state enum, the default image constant and the AW/DW defaults.
REQ-032 Storage sits in sub-module z80_prog_rom_mem: synchronous read, optional write port; the FSM, counter and output registers stay in z80_prog_rom.

Verification
REQ-033 rst held 2 cycles, then released -> dout=FF, dout_en=0, n_wait=1 immediately after reset.
REQ-034 WAIT_CYC=1, n_ce low with addr=0x02, n_oe low -> n_wait low for 1 cycle; dout=3C at cycle 2; dout_en=1 at cycle 3.
REQ-035 WAIT_CYC=0, addr=0x06 -> dout=C3 at cycle 1, n_wait stays 1; addr changed to 0x07 while n_ce low -> dout remains C3.
REQ-036 Macro defined, ld_we writes 0x55 to addr 0x00 on the same edge the read is captured -> dout=3E; next access to 0x00 -> dout=55.
REQ-037 Read addr 0xF0 with DEPTH=16 -> dout=FF.
REQ-038 rst asserted during WAIT (WAIT_CYC=3) -> next cycle IDLE, n_wait=1, dout_en=0; next access runs a normal full sequence.

Source files
------------

// File: rtl/z80_mc_pkg.sv
// Shared types and constants for the Z80 microcontroller slice: FSM states,
// bus width defaults and the default program image.
package z80_mc_pkg;

  localparam int unsigned Z80_AW = 8;
  localparam int unsigned Z80_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DATA
  } state_e;

  localparam int unsigned IMAGE_LEN = 9;
  localparam logic [7:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
    8'h3E, 8'h00, 8'h3C, 8'hC2, 8'h02, 8'h00, 8'hC3, 8'h06, 8'h00
  };

endpackage

// File: rtl/z80_prog_rom_mem.sv
// Program storage with a registered read port; the loader write port exists
// only when Z80_PROG_ROM_LOAD_EN is defined, otherwise the contents are a constant ROM.
module z80_prog_rom_mem
  import z80_mc_pkg::*;
#(
  parameter int unsigned AW    = Z80_AW,
  parameter int unsigned DW    = Z80_DW,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          rd_clr_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
`ifdef Z80_PROG_ROM_LOAD_EN
  ,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
`endif
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [DW-1:0] image_word(input int unsigned idx);
    if (idx < IMAGE_LEN) return DW'(DEFAULT_IMAGE[idx]);
    return '1;
  endfunction

  logic [DW-1:0] rd_data_q, rd_data_d, rd_word;
  logic          rd_in_range;

  assign rd_in_range = 32'(rd_addr_i) < 32'(DEPTH);

`ifdef Z80_PROG_ROM_LOAD_EN
  typedef logic [DW-1:0] mem_t [DEPTH];

  function automatic mem_t init_image();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) m[i] = image_word(i);
    return m;
  endfunction

  mem_t mem_q = init_image();

  // Writes beyond DEPTH are dropped rather than aliased onto low words.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (32'(wr_addr_i) < 32'(DEPTH))) mem_q[wr_addr_i[IW-1:0]] <= wr_data_i;
  end

  assign rd_word = mem_q[rd_addr_i[IW-1:0]];
`else
  assign rd_word = image_word(32'(rd_addr_i));
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr_i)     rd_data_d = '1;
    else if (rd_en_i) rd_data_d = rd_in_range ? rd_word : '1;
  end

  always_ff @(posedge clk_i) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/z80_prog_rom.sv
// Z80 program ROM bus interface: chip-enable driven access FSM with wait states.
// Defining Z80_PROG_ROM_LOAD_EN adds the ld_* loader write port.
module z80_prog_rom
  import z80_mc_pkg::*;
#(
  parameter int unsigned AW       = Z80_AW,
  parameter int unsigned DW       = Z80_DW,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          n_ce,
  input  logic          n_oe,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          dout_en,
  output logic          n_wait
`ifdef Z80_PROG_ROM_LOAD_EN
  ,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
`endif
);

  localparam logic [2:0] CNT_LAST = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic          dout_en_q;
  logic          n_wait_q;

  logic          rd_en;
  logic          rd_clr;
  logic [AW-1:0] rd_addr;

  // The read is issued on the edge that enters DATA; with no wait states that
  // is the latching edge itself, so the live address is used from IDLE.
  always_comb begin
    rd_addr = (state_q == IDLE) ? addr : addr_q;
    rd_en   = 1'b0;
    if (!n_ce) begin
      if ((state_q == IDLE) && (WAIT_CYC == 0))     rd_en = 1'b1;
      if ((state_q == WAIT) && (cnt_q == CNT_LAST)) rd_en = 1'b1;
    end
    rd_clr = rst || (n_ce && (state_q != IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dout_en_q <= 1'b0;
      n_wait_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!n_ce) begin
            addr_q <= addr;
            cnt_q  <= '0;
            if (WAIT_CYC > 0) begin
              state_q  <= WAIT;
              n_wait_q <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        WAIT: begin
          if (n_ce) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dout_en_q <= 1'b0;
            n_wait_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= DATA;
            cnt_q    <= '0;
            n_wait_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        DATA: begin
          if (n_ce) begin
            state_q   <= IDLE;
            dout_en_q <= 1'b0;
            n_wait_q  <= 1'b1;
          end else begin
            dout_en_q <= ~n_oe;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          dout_en_q <= 1'b0;
          n_wait_q  <= 1'b1;
        end
      endcase
    end
  end

  z80_prog_rom_mem #(
    .AW   (AW),
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i    (clk),
    .rd_clr_i (rd_clr),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(dout)
`ifdef Z80_PROG_ROM_LOAD_EN
    ,
    .wr_en_i  (ld_we),
    .wr_addr_i(ld_addr),
    .wr_data_i(ld_data)
`endif
  );

  assign dout_en = dout_en_q;
  assign n_wait  = n_wait_q;

endmodule

// File: tb/tb_z80_prog_rom.sv
// Bench for z80_prog_rom: three configurations share the bus stimulus and are
// checked every cycle against an access-level model of the read timing.
module tb_z80_prog_rom;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 0, 3};
  localparam int DP [NI] = '{256, 16, 256};

  logic       clk;
  logic       rst;
  logic       n_ce;
  logic       n_oe;
  logic [7:0] addr;
`ifdef Z80_PROG_ROM_LOAD_EN
  logic       ld_we;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
`endif

  logic [7:0] dout_w1, dout_w0, dout_w3;
  logic       en_w1, en_w0, en_w3;
  logic       nw_w1, nw_w0, nw_w3;
  logic [7:0] dout_v [NI];
  logic       en_v [NI];
  logic       nw_v [NI];

  int checks;
  int failures;

  logic [7:0] mem_m [NI][256];
  logic [7:0] od  [NI][16];
  logic       oen [NI][16];
  logic       onw [NI][16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  z80_prog_rom #(.AW(8), .DW(8), .DEPTH(256), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .rst(rst), .n_ce(n_ce), .n_oe(n_oe), .addr(addr),
    .dout(dout_w1), .dout_en(en_w1), .n_wait(nw_w1)
`ifdef Z80_PROG_ROM_LOAD_EN
    , .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`endif
  );

  z80_prog_rom #(.AW(8), .DW(8), .DEPTH(16), .WAIT_CYC(0)) u_w0 (
    .clk(clk), .rst(rst), .n_ce(n_ce), .n_oe(n_oe), .addr(addr),
    .dout(dout_w0), .dout_en(en_w0), .n_wait(nw_w0)
`ifdef Z80_PROG_ROM_LOAD_EN
    , .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`endif
  );

  z80_prog_rom #(.AW(8), .DW(8), .DEPTH(256), .WAIT_CYC(3)) u_w3 (
    .clk(clk), .rst(rst), .n_ce(n_ce), .n_oe(n_oe), .addr(addr),
    .dout(dout_w3), .dout_en(en_w3), .n_wait(nw_w3)
`ifdef Z80_PROG_ROM_LOAD_EN
    , .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`endif
  );

  assign dout_v[0] = dout_w1;
  assign dout_v[1] = dout_w0;
  assign dout_v[2] = dout_w3;
  assign en_v[0]   = en_w1;
  assign en_v[1]   = en_w0;
  assign en_v[2]   = en_w3;
  assign nw_v[0]   = nw_w1;
  assign nw_v[1]   = nw_w0;
  assign nw_v[2]   = nw_w3;

  task automatic model_init();
    logic [7:0] img [9];
    img = '{8'h3E, 8'h00, 8'h3C, 8'hC2, 8'h02, 8'h00, 8'hC3, 8'h06, 8'h00};
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) mem_m[i][a] = (a < 9) ? img[a] : 8'hFF;
  endtask

  // One access: n_ce low for len edges (edge 0 latches a), then one edge with
  // n_ce high, or with rst high when end_rst is set.
  task automatic run_access(input logic [7:0] a, input int len, input bit oe_low,
                            input int wr_edge, input logic [7:0] wr_d,
                            input bit rand_wr, input bit end_rst);
    logic [7:0] cap [NI];
    logic [7:0] e_d;
    logic       e_en, e_nw, noe;
    for (int i = 0; i < NI; i++) cap[i] = 8'hFF;
    for (int j = 0; j <= len; j++) begin
      if (j < len) begin
        n_ce = 1'b0;
        addr = (j == 0) ? a : 8'($urandom_range(0, 255));
        n_oe = oe_low ? 1'b0 : 1'($urandom_range(0, 1));
      end else begin
        n_ce = 1'b1;
        n_oe = 1'($urandom_range(0, 1));
        rst  = end_rst;
      end
      noe = n_oe;
      for (int i = 0; i < NI; i++)
        if (j < len && j == WC[i]) cap[i] = (int'(a) < DP[i]) ? mem_m[i][a] : 8'hFF;
`ifdef Z80_PROG_ROM_LOAD_EN
      ld_we = 1'b0;
      if (j == wr_edge) begin
        ld_we = 1'b1; ld_addr = a; ld_data = wr_d;
      end else if (rand_wr && $urandom_range(0, 3) == 0) begin
        ld_we = 1'b1; ld_addr = 8'($urandom_range(0, 255)); ld_data = 8'($urandom);
      end
      if (ld_we)
        for (int i = 0; i < NI; i++) if (int'(ld_addr) < DP[i]) mem_m[i][ld_addr] = ld_data;
`endif
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (j == len) begin
          e_d = 8'hFF; e_en = 1'b0; e_nw = 1'b1;
        end else begin
          e_nw = (j < WC[i]) ? 1'b0 : 1'b1;
          e_d  = (j >= WC[i]) ? cap[i] : 8'hFF;
          e_en = (j >= WC[i] + 1) && !noe;
        end
        od[i][j+1] = dout_v[i]; oen[i][j+1] = en_v[i]; onw[i][j+1] = nw_v[i];
        checks++;
        if (dout_v[i] !== e_d) begin
          failures++;
          $display("FAIL acc_dout inst=%0d a=%h k=%0d got=%h exp=%h", i, a, j + 1, dout_v[i], e_d);
        end
        checks++;
        if (en_v[i] !== e_en) begin
          failures++;
          $display("FAIL acc_dout_en inst=%0d a=%h k=%0d got=%b exp=%b", i, a, j + 1, en_v[i], e_en);
        end
        checks++;
        if (nw_v[i] !== e_nw) begin
          failures++;
          $display("FAIL acc_n_wait inst=%0d a=%h k=%0d got=%b exp=%b", i, a, j + 1, nw_v[i], e_nw);
        end
      end
    end
    rst  = 1'b0;
    n_ce = 1'b1;
`ifdef Z80_PROG_ROM_LOAD_EN
    ld_we = 1'b0;
`endif
    if (end_rst) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dout_v[i] !== 8'hFF || en_v[i] !== 1'b0 || nw_v[i] !== 1'b1) begin
          failures++;
          $display("FAIL post_rst_idle inst=%0d got=%h/%b/%b exp=ff/0/1", i, dout_v[i], en_v[i], nw_v[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; n_ce = 1'b1; n_oe = 1'b1; addr = '0;
`ifdef Z80_PROG_ROM_LOAD_EN
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (dout_v[i] !== 8'hFF || en_v[i] !== 1'b0 || nw_v[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_state inst=%0d got=%h/%b/%b exp=ff/0/1", i, dout_v[i], en_v[i], nw_v[i]);
      end
    end
  endtask

  task automatic test_wait_one();
    run_access(8'h02, 4, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (onw[0][1] !== 1'b0 || onw[0][2] !== 1'b1) begin
      failures++;
      $display("FAIL w1_n_wait got=%b%b exp=01", onw[0][1], onw[0][2]);
    end
    checks++;
    if (od[0][2] !== 8'h3C) begin
      failures++;
      $display("FAIL w1_dout got=%h exp=3c", od[0][2]);
    end
    checks++;
    if (oen[0][2] !== 1'b0 || oen[0][3] !== 1'b1) begin
      failures++;
      $display("FAIL w1_dout_en got=%b%b exp=01", oen[0][2], oen[0][3]);
    end
  endtask

  task automatic test_wait_zero();
    run_access(8'h06, 5, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (od[1][1] !== 8'hC3 || od[1][5] !== 8'hC3) begin
      failures++;
      $display("FAIL w0_dout_hold got=%h,%h exp=c3,c3", od[1][1], od[1][5]);
    end
    checks++;
    if (onw[1][1] !== 1'b1) begin
      failures++;
      $display("FAIL w0_n_wait got=%b exp=1", onw[1][1]);
    end
  endtask

  task automatic test_out_of_range();
    run_access(8'hF0, 3, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (od[1][1] !== 8'hFF) begin
      failures++;
      $display("FAIL oor_dout got=%h exp=ff", od[1][1]);
    end
    run_access(8'h08, 3, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (od[1][1] !== 8'h00) begin
      failures++;
      $display("FAIL in_range_dout got=%h exp=00", od[1][1]);
    end
  endtask

  task automatic test_rbw();
`ifdef Z80_PROG_ROM_LOAD_EN
    run_access(8'h00, 5, 1'b1, 1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (od[0][2] !== 8'h3E) begin
      failures++;
      $display("FAIL rbw_old got=%h exp=3e", od[0][2]);
    end
    checks++;
    if (od[2][4] !== 8'h55) begin
      failures++;
      $display("FAIL rbw_late_capture got=%h exp=55", od[2][4]);
    end
    run_access(8'h00, 4, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (od[0][2] !== 8'h55) begin
      failures++;
      $display("FAIL rbw_new got=%h exp=55", od[0][2]);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    run_access(8'h03, 2, 1'b1, -1, 8'h00, 1'b0, 1'b1);
    checks++;
    if (onw[2][1] !== 1'b0 || onw[2][2] !== 1'b0 || onw[2][3] !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_n_wait got=%b%b%b exp=001", onw[2][1], onw[2][2], onw[2][3]);
    end
    run_access(8'h03, 6, 1'b1, -1, 8'h00, 1'b0, 1'b0);
    checks++;
    if (od[2][4] !== 8'hC2 || onw[2][3] !== 1'b0 || onw[2][4] !== 1'b1 || oen[2][5] !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_rerun got=%h/%b%b/%b exp=c2/01/1", od[2][4], onw[2][3], onw[2][4], oen[2][5]);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      run_access(a, int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)), -1, 8'h00,
                 1'b1, ($urandom_range(0, 4) == 0));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_init();
    test_reset();
    test_wait_one();
    test_wait_zero();
    test_out_of_range();
    test_rbw();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
